alu_seq8: RTL and testbench

ALU_SEQ8 -- requirements
Module: alu_seq8

---
 rtl/alu_seq8.sv | 135 +++++++++++++
 tb/tb_alu_seq8.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq8.sv
// 8-bit add/sub/nand sequencer driving an external 4-bit ALU nibble by nibble.
// Optional ALU_SEQ_ZERO_FLAG_EN adds the rsp_zf zero-result output.
module alu_seq8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_a,
  input  logic [7:0] req_b,
  input  logic [1:0] req_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_r,
  input  logic       alu_cf,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_cf,
  output logic       rsp_err
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic       rsp_zf
`endif
);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_RSV = 2'b10, OP_NAND = 2'b11} op_e;

  state_e     state;
  op_e        op_q;
  logic [7:0] a_q;
  logic [7:0] b_q;
  logic       c_lo;
  logic       c_hi;
  logic       c_fix;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      c_lo       <= 1'b0;
      c_hi       <= 1'b0;
      c_fix      <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q        <= req_a;
            b_q        <= req_b;
            op_q       <= op_e'(req_op);
            c_lo       <= 1'b0;
            c_hi       <= 1'b0;
            c_fix      <= 1'b0;
            req_ready  <= 1'b0;
            rsp_result <= '0;
            if (op_e'(req_op) == OP_RSV) begin
              state     <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state   <= LO;
              rsp_err <= 1'b0;
            end
          end
        end
        LO: begin
          rsp_result[3:0] <= alu_r;
          c_lo            <= alu_cf;
          state           <= HI;
        end
        HI: begin
          rsp_result[7:4] <= alu_r;
          c_hi            <= alu_cf;
          // Low nibble carry (add) or borrow (sub) still owed to the high nibble.
          if ((op_q == OP_ADD && c_lo) || (op_q == OP_SUB && !c_lo)) begin
            state <= FIX;
          end else begin
            state     <= DONE;
            rsp_valid <= 1'b1;
          end
        end
        FIX: begin
          rsp_result[7:4] <= alu_r;
          c_fix           <= alu_cf;
          state           <= DONE;
          rsp_valid       <= 1'b1;
        end
        DONE: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    case (state)
      LO:  begin alu_a = a_q[3:0];        alu_b = b_q[3:0]; alu_op = op_q; end
      HI:  begin alu_a = a_q[7:4];        alu_b = b_q[7:4]; alu_op = op_q; end
      FIX: begin alu_a = rsp_result[7:4]; alu_b = 4'b0001;  alu_op = op_q; end
      default: ;
    endcase
  end

  // c_fix is cleared on acceptance, so add without a FIX pass reduces to c_hi.
  always_comb begin
    rsp_cf = 1'b0;
    if (state == DONE) begin
      case (op_q)
        OP_ADD:  rsp_cf = c_hi | c_fix;
        OP_SUB:  rsp_cf = c_lo ? c_hi : (c_hi & c_fix);
        default: rsp_cf = 1'b0;
      endcase
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign rsp_zf = rsp_valid && (rsp_result == 8'h00);
`endif

endmodule

// File: tb/tb_alu_seq8.sv
// Scoreboard bench for alu_seq8 with a behavioural 4-bit ALU and an 8-bit reference model.
module tb_alu_seq8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_a = '0;
  logic [7:0] req_b = '0;
  logic [1:0] req_op = '0;
  logic [3:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_cf;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_result;
  logic       rsp_cf, rsp_err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       rsp_zf;
`endif

  alu_seq8 dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_r(alu_r), .alu_cf(alu_cf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_cf(rsp_cf), .rsp_err(rsp_err)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    , .rsp_zf(rsp_zf)
`endif
  );

  always #5 clk = ~clk;

  // External 4-bit ALU
  always_comb begin
    alu_r  = '0;
    alu_cf = 1'b0;
    case (alu_op)
      2'b00: {alu_cf, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: begin alu_r = alu_a - alu_b; alu_cf = (alu_a >= alu_b); end
      2'b11: alu_r = ~(alu_a & alu_b);
      default: ;
    endcase
  end

  typedef struct {
    logic [7:0]  res;
    logic        cf;
    logic        err;
    logic        zf;
    logic        fix;
    logic [3:0]  bhi;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic        hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    exp_t e;
    logic [8:0] s;
    e.err = 1'b0; e.cf = 1'b0; e.fix = 1'b0; e.res = '0; e.lat = 3;
    e.bhi = b[7:4]; e.acc = 0;
    case (op)
      2'b00: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[7:0]; e.cf = s[8];
        e.fix = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
      end
      2'b01: begin
        e.res = a - b; e.cf = (a >= b);
        e.fix = (a[3:0] < b[3:0]);
      end
      2'b11: e.res = ~(a & b);
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    if (e.fix) e.lat = 4;
    e.zf = (e.res == 8'h00);
    return e;
  endfunction

  // Consumer back-pressure
  initial forever begin
    @(negedge clk);
    rsp_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor
  initial begin
    exp_t        cur;
    logic        in_rsp = 1'b0;
    logic [3:0]  last_b = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() > 0 && exp_q[0].err)
          chk("err_alu_op_zero", {30'd0, alu_op}, 32'd0);
        if (!rsp_valid) begin
          in_rsp = 1'b0;
        end else begin
          chk("busy_req_ready", {31'd0, req_ready}, 32'd0);
          chk("done_alu_idle", {20'd0, alu_a, alu_b, alu_op}, 32'd0);
          if (!in_rsp) begin
            in_rsp = 1'b1;
            if (exp_q.size() == 0) begin
              chk("unexpected_rsp", 32'd1, 32'd0);
              cur.res = rsp_result; cur.cf = rsp_cf; cur.err = rsp_err;
            end else begin
              cur = exp_q.pop_front();
              chk("rsp_result", {24'd0, rsp_result}, {24'd0, cur.res});
              chk("rsp_cf", {31'd0, rsp_cf}, {31'd0, cur.cf});
              chk("rsp_err", {31'd0, rsp_err}, {31'd0, cur.err});
              chk("latency", cyc - cur.acc + 1, cur.lat);
`ifdef ALU_SEQ_ZERO_FLAG_EN
              chk("rsp_zf", {31'd0, rsp_zf}, {31'd0, cur.zf});
`endif
              if (cur.fix) chk("fix_alu_b", {28'd0, last_b}, 32'd1);
              else if (!cur.err) chk("hi_alu_b", {28'd0, last_b}, {28'd0, cur.bhi});
            end
          end else begin
            chk("stable_result", {24'd0, rsp_result}, {24'd0, cur.res});
            chk("stable_flags", {30'd0, rsp_cf, rsp_err}, {30'd0, cur.cf, cur.err});
          end
        end
      end
      last_b = alu_b;
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic directed, input logic [7:0] e_res, input logic e_cf,
                       input int unsigned e_lat);
    exp_t e;
    int unsigned guard = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    while (!req_ready && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    e = model(a, b, op);
    if (directed) begin
      e.res = e_res; e.cf = e_cf; e.lat = e_lat;
      e.fix = (e_lat == 4); e.zf = (e_res == 8'h00); e.err = (op == 2'b10);
    end
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int unsigned guard = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || rsp_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0 || rsp_valid) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int unsigned guard;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_rsp", {21'd0, rsp_valid, rsp_result, rsp_cf, rsp_err}, 32'd0);
    chk("reset_alu", {20'd0, alu_a, alu_b, alu_op}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, req_ready}, 32'd1);

    issue(8'h3A, 8'h0C, 2'b00, 1'b1, 8'h46, 1'b0, 4); drain();
    issue(8'hFF, 8'h01, 2'b00, 1'b1, 8'h00, 1'b1, 4); drain();
    issue(8'h10, 8'h01, 2'b01, 1'b1, 8'h0F, 1'b1, 4); drain();
    issue(8'h00, 8'h01, 2'b01, 1'b1, 8'hFF, 1'b0, 4); drain();
    issue(8'hF0, 8'hFF, 2'b11, 1'b1, 8'h0F, 1'b0, 3); drain();
    issue(8'h5A, 8'hA5, 2'b10, 1'b1, 8'h00, 1'b0, 1); drain();
    issue(8'h12, 8'h34, 2'b00, 1'b1, 8'h46, 1'b0, 3); drain();

    // Back-pressure: response must hold while rsp_ready stays low
    hold = 1'b1;
    issue(8'h55, 8'h22, 2'b00, 1'b1, 8'h77, 1'b0, 3);
    guard = 0;
    while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_result", {24'd0, rsp_result}, 32'h77);
      @(negedge clk);
    end
    hold = 1'b0;
    drain();

    // Reset while the high nibble is in flight
    issue(8'h3A, 8'h0C, 2'b00, 1'b0, 8'h00, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("in_hi_alu_b", {28'd0, alu_b}, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_hi_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_hi_rsp", {21'd0, rsp_valid, rsp_result, rsp_cf, rsp_err}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("rst_hi_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    issue(8'h80, 8'h80, 2'b00, 1'b1, 8'h00, 1'b1, 3); drain();

    for (int n = 0; n < 150; n++)
      issue(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 1'b0, 8'h00, 1'b0, 0);
    drain();
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
